frame_streamer: RTL and testbench
=================================

FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 SHALL have parameter LCD_WIDTH, default 240, meaning display columns.
REQ-002 SHALL have parameter LCD_HEIGHT, default 320, meaning display rows.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, meaning pixel colour width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 17, meaning source memory address width.
REQ-005 SHALL have port clock  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  begin one window blit; sampled only in IDLE.
REQ-008 SHALL have port winX  input  8  window left column on display.
REQ-009 SHALL have port winY  input  9  window top row on display.
REQ-010 SHALL have port winW  input  9  window width in pixels, 0..LCD_WIDTH.
REQ-011 SHALL have port winH  input  9  window height in pixels, 0..LCD_HEIGHT.
REQ-012 SHALL have port memAddr  output  ADDR_WIDTH  linear source address, row-major.
REQ-013 SHALL have port memRdData  input  DATA_WIDTH  source data, valid one cycle after memAddr.
REQ-014 SHALL have ports xAddr output 8, yAddr output 9, pixelData output DATA_WIDTH  display pixel.
REQ-015 SHALL have port pixelWrite  output  1  pixel valid to display.
REQ-016 SHALL have port pixelReady  input  1  display accepts pixel.
REQ-017 SHALL have ports busy output 1 (not IDLE) and done output 1 (one-cycle completion pulse).

Function
REQ-018 SHALL implement states IDLE, READ, LOAD, WRITE, DONE.
REQ-019 SHALL in IDLE on start=1 latch winX/winY/winW/winH, clear col/row/memAddr to 0, go READ; if latched winW=0 or winH=0 go DONE with no writes.
REQ-020 SHALL hold memAddr in READ, then in LOAD register memRdData into pixelData and xAddr=winX+col, yAddr=winY+row.
REQ-021 SHALL in WRITE assert pixelWrite with xAddr/yAddr/pixelData stable until a cycle with pixelReady=1; transfer occurs on that edge.
REQ-022 SHALL give first pixelWrite=1 exactly 3 cycles after the start-sampling edge.
REQ-023 SHALL after each transfer increment memAddr by 1 and col; at col=winW-1 wrap col to 0 and increment row; after col=winW-1,row=winH-1 go DONE, else READ.
REQ-024 SHALL generate memAddr by increment only (no multiplier); computed xAddr/yAddr use 9/10-bit intermediates.
REQ-025 SHALL clip: pixels with winX+col>=LCD_WIDTH or winY+row>=LCD_HEIGHT skip WRITE (no pixelWrite) but still advance memAddr/col/row.
REQ-026 SHALL assert done for the single DONE cycle, then return to IDLE; busy=1 in READ, LOAD, WRITE, DONE.
REQ-027 SHALL ignore start when not IDLE; window inputs changed mid-blit SHALL have no effect.
REQ-028 SHALL deassert pixelWrite in every state except WRITE.

Reset
REQ-029 SHALL on reset_n=0 immediately force IDLE, memAddr=0, xAddr=0, yAddr=0, pixelData=0, pixelWrite=0, busy=0, done=0, col=row=0.
REQ-030 SHALL abandon any blit on reset mid-operation; no pixelWrite until a new start after reset release.

Configuration
REQ-031 SHALL with macro FRAME_STREAMER_COLOUR_KEY_EN defined add inputs keyEnable (1) and colourKey (DATA_WIDTH); when keyEnable=1 and loaded pixel equals colourKey, skip WRITE as in REQ-025.
REQ-032 SHALL without FRAME_STREAMER_COLOUR_KEY_EN have no keyEnable/colourKey ports and write every unclipped pixel.

Verification
REQ-033 Full screen: winX=0,winY=0,winW=240,winH=320, pixelReady=1 always -> 76800 writes, memAddr 0..76799, last xAddr=239,yAddr=319, one done pulse.
REQ-034 Back-pressure: winW=2,winH=2, pixelReady low 5 cycles in first WRITE -> pixelWrite held, outputs stable, exactly 4 transfers, done once.
REQ-035 Clip: winX=238,winY=0,winW=4,winH=1 -> writes at x=238,239 only; memAddr reaches 3; done pulses.
REQ-036 Zero size: winW=0,winH=5, start -> no pixelWrite, done=1 on the cycle after start sampled.
REQ-037 Reset mid-blit: reset_n low during WRITE of pixel 10 -> all outputs 0 asynchronously; start ignored mid-blit; restart blits from memAddr 0.
REQ-038 Colour key (macro defined): keyEnable=1, colourKey=16'hF81F, source pixel 1 = F81F in 3x1 window -> writes x=winX and winX+2 only.

Source files
------------

// File: rtl/frame_streamer.sv
// Window blitter: streams a winW x winH block from linear source memory to display
// coordinates with clipping. Optional colour-key skip under FRAME_STREAMER_COLOUR_KEY_EN.
module frame_streamer #(
  parameter int LCD_WIDTH  = 240,
  parameter int LCD_HEIGHT = 320,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            winX,
  input  logic [8:0]            winY,
  input  logic [8:0]            winW,
  input  logic [8:0]            winH,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0] memRdData,
  output logic [7:0]            xAddr,
  output logic [8:0]            yAddr,
  output logic [DATA_WIDTH-1:0] pixelData,
  output logic                  pixelWrite,
  input  logic                  pixelReady,
  output logic                  busy,
  output logic                  done
`ifdef FRAME_STREAMER_COLOUR_KEY_EN
  ,
  input  logic                  keyEnable,
  input  logic [DATA_WIDTH-1:0] colourKey
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [8:0] C_LCD_W = 9'(LCD_WIDTH);
  localparam logic [9:0] C_LCD_H = 10'(LCD_HEIGHT);

  logic [2:0]            r_state;
  logic [7:0]            r_winX;
  logic [8:0]            r_winY, r_winW, r_winH;
  logic [8:0]            r_col, r_row;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic [7:0]            r_xAddr;
  logic [8:0]            r_yAddr;
  logic [DATA_WIDTH-1:0] r_pixelData;

  logic [8:0] w_xSum;
  logic [9:0] w_ySum;
  logic       w_clip, w_key, w_skip, w_lastCol, w_last, w_step, w_begin;

  // Widened sums so off-screen coordinates compare correctly before truncation.
  assign w_xSum    = {1'b0, r_winX} + r_col;
  assign w_ySum    = {1'b0, r_winY} + {1'b0, r_row};
  assign w_clip    = (w_xSum >= C_LCD_W) || (w_ySum >= C_LCD_H);
`ifdef FRAME_STREAMER_COLOUR_KEY_EN
  assign w_key     = keyEnable && (memRdData == colourKey);
`else
  assign w_key     = 1'b0;
`endif
  assign w_skip    = w_clip || w_key;
  assign w_lastCol = (r_col == r_winW - 9'd1);
  assign w_last    = w_lastCol && (r_row == r_winH - 9'd1);
  assign w_begin   = (r_state == S_IDLE) && start;
  // One pixel retires either by a display handshake or by being skipped at load.
  assign w_step    = ((r_state == S_LOAD) && w_skip) ||
                     ((r_state == S_WRITE) && pixelReady);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_winX      <= '0;
      r_winY      <= '0;
      r_winW      <= '0;
      r_winH      <= '0;
      r_xAddr     <= '0;
      r_yAddr     <= '0;
      r_pixelData <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_winX  <= winX;
          r_winY  <= winY;
          r_winW  <= winW;
          r_winH  <= winH;
          r_state <= (winW == 9'd0 || winH == 9'd0) ? S_DONE : S_READ;
        end
        S_READ: r_state <= S_LOAD;
        S_LOAD: begin
          if (w_skip) begin
            r_state <= w_last ? S_DONE : S_READ;
          end else begin
            r_pixelData <= memRdData;
            r_xAddr     <= w_xSum[7:0];
            r_yAddr     <= w_ySum[8:0];
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: if (pixelReady) r_state <= w_last ? S_DONE : S_READ;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The final pixel leaves memAddr on its own address rather than one past it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_memAddr <= '0;
    end else if (w_begin) begin
      r_col     <= '0;
      r_row     <= '0;
      r_memAddr <= '0;
    end else if (w_step && !w_last) begin
      r_memAddr <= r_memAddr + 1'b1;
      r_col     <= w_lastCol ? 9'd0 : r_col + 9'd1;
      r_row     <= w_lastCol ? r_row + 9'd1 : r_row;
    end
  end

  assign memAddr    = r_memAddr;
  assign xAddr      = r_xAddr;
  assign yAddr      = r_yAddr;
  assign pixelData  = r_pixelData;
  assign pixelWrite = (r_state == S_WRITE);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_frame_streamer.sv
// Randomized bench for frame_streamer: a queue of expected display writes is built from
// the window geometry and checked against every handshake.
module tb_frame_streamer;
  localparam int LW = 240, LH = 320, DW = 16, AW = 17;

  logic          clock = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [7:0]    winX = '0;
  logic [8:0]    winY = '0, winW = '0, winH = '0;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memRdData = '0, pixelData;
  logic [7:0]    xAddr;
  logic [8:0]    yAddr;
  logic          pixelWrite, pixelReady = 1'b1, busy, done;
`ifdef FRAME_STREAMER_COLOUR_KEY_EN
  logic          keyEnable = 1'b0;
  logic [DW-1:0] colourKey = '0;
`endif

  frame_streamer #(.LCD_WIDTH(LW), .LCD_HEIGHT(LH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .winX(winX), .winY(winY), .winW(winW), .winH(winH),
    .memAddr(memAddr), .memRdData(memRdData),
    .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
    .pixelWrite(pixelWrite), .pixelReady(pixelReady), .busy(busy), .done(done)
`ifdef FRAME_STREAMER_COLOUR_KEY_EN
    , .keyEnable(keyEnable), .colourKey(colourKey)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] x; logic [8:0] y; logic [DW-1:0] d; } wr_t;
  wr_t expq[$];

  int nchk = 0, nerr = 0;
  int seed;
  int key_addr = -1;
  int rdy_mode = 0, lowcnt = 0;
  int nwr, ndone, nstall;
  logic [AW-1:0] lastA;
  bit first_wr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] src(input int a);
    logic [31:0] t;
    if (a == key_addr) return 16'hF81F;
    t = 32'(a) * 32'h9E3779B1 + 32'(seed);
    return t[31:16];
  endfunction

  always @(posedge clock) memRdData <= src(int'(memAddr));

  // Reference: row-major walk of the window; on-screen, non-keyed pixels are written in order.
  task automatic build_exp(input int x, input int y, input int w, input int h);
    wr_t e;
    logic [DW-1:0] d;
    bit keyed;
    expq.delete();
    first_wr = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        d = src(r * w + c);
        keyed = 0;
`ifdef FRAME_STREAMER_COLOUR_KEY_EN
        keyed = keyEnable && (d == colourKey);
`endif
        if (x + c < LW && y + r < LH && !keyed) begin
          e.x = 8'(x + c); e.y = 9'(y + r); e.d = d;
          expq.push_back(e);
          if (r == 0 && c == 0) first_wr = 1;
        end
      end
  endtask

  initial forever begin
    @(posedge clock); #1;
    case (rdy_mode)
      0: pixelReady = 1'b1;
      1: pixelReady = 1'($urandom_range(0, 1));
      default: begin
        if (pixelWrite && lowcnt < 5) begin pixelReady = 1'b0; lowcnt++; end
        else pixelReady = 1'b1;
      end
    endcase
  end

  // Monitor: scoreboard transfers and hold-stability under back-pressure.
  bit hold = 0;
  logic [7:0] hx; logic [8:0] hy; logic [DW-1:0] hd;
  wr_t me;
  always @(negedge clock) begin
    if (!reset_n) hold = 0;
    else begin
      if (done) begin ndone++; lastA = memAddr; end
      if (hold) begin
        chk("held_write", pixelWrite, 1);
        chk("held_data", {hx, hy, hd}, {xAddr, yAddr, pixelData});
      end
      hold = 0;
      if (pixelWrite) begin
        if (pixelReady) begin
          nwr++;
          if (expq.size() == 0) chk("extra_write", 1, 0);
          else begin
            me = expq.pop_front();
            chk("wr_x", xAddr, me.x);
            chk("wr_y", yAddr, me.y);
            chk("wr_d", pixelData, me.d);
          end
        end else begin
          nstall++;
          hold = 1; hx = xAddr; hy = yAddr; hd = pixelData;
        end
      end
    end
  end

  task automatic run_blit(input int x, input int y, input int w, input int h, input string tag);
    int cyc, first_pw, done_cyc, lim, nexp;
    build_exp(x, y, w, h);
    nexp = expq.size();
    lim = 20 * w * h + 100;
    @(negedge clock);
    nwr = 0; ndone = 0; nstall = 0; lastA = '1;
    winX = 8'(x); winY = 9'(y); winW = 9'(w); winH = 9'(h); start = 1'b1;
    cyc = 0; first_pw = 0; done_cyc = 0;
    do begin
      @(negedge clock); cyc++;
      if (pixelWrite && first_pw == 0) first_pw = cyc;
      if (done && done_cyc == 0) done_cyc = cyc;
      start = busy ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (busy) begin
        winX = 8'($urandom); winY = 9'($urandom); winW = 9'($urandom); winH = 9'($urandom);
      end
    end while (busy && cyc < lim);
    start = 1'b0;
    @(negedge clock);
    chk({tag, "_timeout"}, cyc < lim, 1);
    chk({tag, "_nwr"}, nwr, nexp);
    chk({tag, "_done"}, ndone, 1);
    chk({tag, "_lastA"}, lastA, (w == 0 || h == 0) ? 0 : w * h - 1);
    if (first_wr) chk({tag, "_lat"}, first_pw, 3);
    if (w == 0 || h == 0) chk({tag, "_zcyc"}, done_cyc, 1);
    expq.delete();
  endtask

  initial begin
    int cyc, npw;
    seed = int'($urandom);
    #12;
    chk("rst_mem", memAddr, 0);
    chk("rst_xy", {xAddr, yAddr}, 0);
    chk("rst_pix", pixelData, 0);
    chk("rst_ctl", {pixelWrite, busy, done}, 0);
    @(negedge clock); reset_n = 1'b1;

    rdy_mode = 0; run_blit(0, 0, 3, 1, "lat");
    rdy_mode = 2; lowcnt = 0; run_blit(4, 7, 2, 2, "bp");
    chk("bp_stalls", nstall, 5);
    rdy_mode = 0; run_blit(238, 0, 4, 1, "clipx");
    run_blit(5, 318, 3, 4, "clipy");
    run_blit(0, 0, 0, 5, "zerow");
    run_blit(9, 9, 7, 0, "zeroh");
    run_blit(0, 0, 240, 2, "fullrow");
    run_blit(250, 330, 3, 2, "alloff");

    // Reset in the middle of the WRITE of pixel 10.
    build_exp(10, 3, 20, 2);
    @(negedge clock);
    nwr = 0; ndone = 0;
    winX = 8'd10; winY = 9'd3; winW = 9'd20; winH = 9'd2; start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clock); cyc++;
      start = 1'($urandom_range(0, 1));
    end while (!(pixelWrite && xAddr == 8'd20) && cyc < 200);
    chk("rst_reach", cyc < 200, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_mem", memAddr, 0);
    chk("mid_rst_xy", {xAddr, yAddr}, 0);
    chk("mid_rst_pix", pixelData, 0);
    chk("mid_rst_ctl", {pixelWrite, busy, done}, 0);
    expq.delete();
    start = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0; reset_n = 1'b1;
    npw = 0;
    repeat (10) begin @(negedge clock); if (pixelWrite || busy) npw++; end
    chk("post_rst_idle", npw, 0);
    run_blit(10, 3, 5, 2, "restart");

`ifdef FRAME_STREAMER_COLOUR_KEY_EN
    keyEnable = 1'b1; colourKey = 16'hF81F; key_addr = 1;
    run_blit(20, 40, 3, 1, "ckey");
    keyEnable = 1'b0; key_addr = -1;
`endif

    for (int i = 0; i < 12; i++) begin
      rdy_mode = int'($urandom_range(0, 1));
      run_blit(int'($urandom_range(0, 3) == 0 ? $urandom_range(228, 255) : $urandom_range(0, 255)),
               int'($urandom_range(0, 3) == 0 ? $urandom_range(310, 330) : $urandom_range(0, 320)),
               int'($urandom_range(0, 12)), int'($urandom_range(0, 6)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
